// File: rtl/hazard_detect_unit_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_detect_unit_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hdu_state_e;

    // Select values for the ID/EX control-bubble mux
    localparam logic CTRL_NOP_SEL  = 1'b0;
    localparam logic CTRL_PASS_SEL = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect_unit_compare.sv
// Combinational load-use match between the EX destination and the ID sources.
module hazard_compare
    import hazard_detect_unit_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    output logic              hazard_c
);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    always_comb begin
        hazard_c = idex_memread && (idex_rd != '0) &&
                   ((idex_rd == id_rs1) || (id_use_rs2 && (idex_rd == id_rs2)));
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard controller: load-use stalls and branch flushes with same-cycle outputs.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned LOAD_STALLS  = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              branch_taken,
    output logic              stall_signal,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    localparam int unsigned CNT_W = $clog2(max_u(LOAD_STALLS, FLUSH_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'((LOAD_STALLS  > 1) ? LOAD_STALLS  - 2 : 0);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    hdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hazard;

    hazard_compare #(.REG_AW(REG_AW)) u_compare (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .hazard_c     (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and same-cycle output decode; branch beats stall continuation beats new hazard
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_signal = CTRL_PASS_SEL;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;

        case (state)
            ST_RUN, ST_STALL: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end
                end else if (state == ST_STALL) begin
                    stall_signal = CTRL_NOP_SEL;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    if (cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end else if (hazard) begin
                    stall_signal = CTRL_NOP_SEL;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    if (LOAD_STALLS > 1) begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = LOAD_RELOAD;
                    end
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs follow reset immediately, independent of the ID/EX inputs
        if (!rst_n) begin
            stall_signal = CTRL_PASS_SEL;
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((stall_signal == CTRL_NOP_SEL) && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench: two instances (1/1 and 3/2 stall/flush lengths) share one stimulus.
module tb_hazard_detect_unit;

    localparam logic [4:0] PASS = 5'b11100;
    localparam logic [4:0] STL  = 5'b00000;
    localparam logic [4:0] FLS  = 5'b11111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       id_use_rs2, idex_memread, branch_taken;

    logic b_stall, b_pcw, b_ifw, b_iff, b_idf;
    logic l_stall, l_pcw, l_ifw, l_iff, l_idf;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] b_scnt, b_fcnt, l_scnt, l_fcnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_detect_unit #(.REG_AW(5), .LOAD_STALLS(1), .FLUSH_CYCLES(1)) u_base (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
        .stall_signal(b_stall), .pc_write(b_pcw), .ifid_write(b_ifw),
        .ifid_flush(b_iff), .idex_flush(b_idf)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(b_scnt), .flush_count(b_fcnt)
`endif
    );

    hazard_detect_unit #(.REG_AW(5), .LOAD_STALLS(3), .FLUSH_CYCLES(2)) u_long (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
        .stall_signal(l_stall), .pc_write(l_pcw), .ifid_write(l_ifw),
        .ifid_flush(l_iff), .idex_flush(l_idf)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(l_scnt), .flush_count(l_fcnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                         input logic mr, input logic [4:0] rd, input logic br);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs2   = use2;
        idex_memread = mr;
        idex_rd      = rd;
        branch_taken = br;
    endtask

    function automatic logic [4:0] outs_b();
        return {b_stall, b_pcw, b_ifw, b_iff, b_idf};
    endfunction

    function automatic logic [4:0] outs_l();
        return {l_stall, l_pcw, l_ifw, l_iff, l_idf};
    endfunction

    // One pipeline cycle: drive just after the edge, compare mid-cycle
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic [4:0] exp_b, input logic [4:0] exp_l, input string tag);
        @(posedge clk);
        #1;
        drive(rs1, rs2, use2, mr, rd, br);
        #1;
        check({tag, "/base"}, 32'(outs_b()), 32'(exp_b));
        check({tag, "/long"}, 32'(outs_l()), 32'(exp_l));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        check("reset/base", 32'(outs_b()), 32'(PASS));
        check("reset/long", 32'(outs_l()), 32'(PASS));
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        #1;
        check("reset_gate_hz/base", 32'(outs_b()), 32'(PASS));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs1: one bubble for base, three for long
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL,  STL,  "ld_use");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, STL,  "stall2");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, STL,  "stall3");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, PASS, "stall_end");
`ifdef HAZARD_PERF_CNT_EN
        check("scnt/base", b_scnt, 32'd1);
        check("scnt/long", l_scnt, 32'd3);
`endif

        // x0 destination and unused rs2 never stall; used rs2 does
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, PASS, PASS, "x0");
        step(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, PASS, PASS, "rs2_unused");
        step(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, STL,  STL,  "rs2_used");

        // Branch aborts the long stall; hazard during flush is ignored
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, FLS,  FLS,  "br_in_stall");
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL,  FLS,  "flush_ign_hz");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, PASS, "flush_done");

        // Branch and hazard together: branch wins
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, FLS,  FLS,  "br_hz");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, FLS,  "flush2");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, PASS, "run_again");

        // Asynchronous reset in the middle of a long stall
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL,  STL,  "pre_rst");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, STL,  "mid_stall");
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst/long", 32'(outs_l()), 32'(PASS));
`ifdef HAZARD_PERF_CNT_EN
        check("rst_scnt/long", l_scnt, 32'd0);
        check("rst_fcnt/long", l_fcnt, 32'd0);
`endif
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        #1;
        check("rst_gate/base", 32'(outs_b()), 32'(PASS));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, PASS, PASS, "post_rst");
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL,  STL,  "post_rst_hz");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
